me_mv_decision: RTL and testbench
=================================

ME_MV_DECISION -- requirements
Module: me_mv_decision

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 frame_start  input  1  one-cycle pulse; opens a new search window, clears all minima.
REQ-004 frame_done  input  1  one-cycle pulse; closes the window, starts result emission.
REQ-005 sad_valid  input  1  SAD sample present this cycle.
REQ-006 sad_cb  input  2  coding sub-block index 0..3 (matches abs_Control encoding).
REQ-007 sad_value  input  16  unsigned SAD of the sample.
REQ-008 sad_row  input  7  search_row_count of the sample.
REQ-009 sad_col  input  5  search_column_count of the sample.
REQ-010 busy  output  1  high in COLLECT and EMIT.
REQ-011 result_valid  output  1  result word present.
REQ-012 result_ready  input  1  consumer accepts result when high with result_valid.
REQ-013 result_cb  output  2  sub-block of current result.
REQ-014 result_row  output  7  row of best candidate.
REQ-015 result_col  output  5  column of best candidate.
REQ-016 result_hit  output  1  1 if at least one sample was seen for this CB.
REQ-017 result_sad  output  16  best SAD (present only with SAD_REPORT_EN).

Function
REQ-018 States IDLE, COLLECT, EMIT; IDLE->COLLECT on frame_start; COLLECT->EMIT on frame_done; EMIT->IDLE after CB3 accepted.
REQ-019 frame_start in any state: clear four slots (sad=16'hFFFF, row=0, col=0, hit=0), go to COLLECT next cycle; drops any pending result.
REQ-020 COLLECT: sad_valid with sad_value strictly less than slot[sad_cb].sad updates that slot (sad,row,col) next cycle; hit set on any valid sample.
REQ-021 Ties keep the earlier candidate; sad_value=16'hFFFF on an unhit slot sets hit, row, col.
REQ-022 sad_valid ignored in IDLE and EMIT; frame_done ignored outside COLLECT.
REQ-023 frame_done and sad_valid in the same cycle: sample is applied, then EMIT.
REQ-024 EMIT: results issued in order CB0,CB1,CB2,CB3; result_valid rises the cycle after entering EMIT.
REQ-025 Result fields stable while result_valid=1 and result_ready=0; on handshake next CB presented the following cycle (one result per cycle max with ready held high).
REQ-026 Handshake on CB3: result_valid=0 and state IDLE next cycle; busy low.
REQ-027 No arithmetic wrap: comparison is 16-bit unsigned, no accumulation.

Reset
REQ-028 rst (sync, active-high) forces IDLE, busy=0, result_valid=0, result_cb=0, result_row=0, result_col=0, result_hit=0, result_sad=16'hFFFF, all slots cleared; dominates frame_start.
REQ-029 rst mid-COLLECT or mid-EMIT discards all state; no partial result emitted.

Configuration
REQ-030 SAD_REPORT_EN defined: result_sad port exists, carries slot best SAD.
REQ-031 SAD_REPORT_EN undefined: result_sad port absent; slot SAD still stored for comparison; all else identical.

Structure
REQ-032 Package me_pkg holds state enum, SAD_W=16, ROW_W=7, COL_W=5, CB_NUM=4, SAD_INIT=16'hFFFF.
REQ-033 Sub-module me_min_slot (one compare/update slot: clear, update strobe, sad/row/col/hit storage) instantiated CB_NUM times.

Verification
REQ-034 frame_start; CB0 samples (sad 500,r3,c1),(300,r9,c2),(300,r12,c4); frame_done; ready=1 -> CB0 result row 9, col 2, hit 1, sad 300.
REQ-035 Samples only for CB2 -> CB0/1/3 results hit 0, row 0, col 0, sad 16'hFFFF; CB2 hit 1.
REQ-036 EMIT with result_ready low 5 cycles -> CB0 fields unchanged all 5 cycles; ready high 4 cycles -> CB0..CB3 in consecutive cycles, then busy 0.
REQ-037 frame_done same cycle as sad_valid (CB1, sad 10, r40, c7) -> CB1 result reports sad 10, r40, c7.
REQ-038 rst during EMIT after CB1 accepted -> next cycle result_valid 0, IDLE; new frame_start gives fresh minima (no stale values).
REQ-039 sad_valid pulses in IDLE and during EMIT -> no slot changes; frame_start during EMIT -> restart COLLECT, pending result dropped.

Source files
------------

// File: rtl/me_pkg.sv
// Shared types and widths for the motion-vector decision block.
// Optional feature: define SAD_REPORT_EN to expose the best SAD on the result bus.
package me_pkg;

    localparam int SAD_W  = 16;
    localparam int ROW_W  = 7;
    localparam int COL_W  = 5;
    localparam int CB_NUM = 4;
    localparam int CB_W   = $clog2(CB_NUM);

    // Value an empty slot holds; any real sample compares as no worse.
    localparam logic [SAD_W-1:0] SAD_INIT = 16'hFFFF;

    typedef logic [CB_W-1:0] cb_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } state_t;

endpackage

// File: rtl/me_mv_decision_if.sv
// SAD sample input bus and result output bus of me_mv_decision.
// Optional feature: SAD_REPORT_EN adds result_sad to the result bus.
interface me_mv_decision_if;
    import me_pkg::*;

    logic             frame_start;
    logic             frame_done;
    logic             sad_valid;
    cb_t              sad_cb;
    logic [SAD_W-1:0] sad_value;
    logic [ROW_W-1:0] sad_row;
    logic [COL_W-1:0] sad_col;

    logic             busy;
    logic             result_valid;
    logic             result_ready;
    cb_t              result_cb;
    logic [ROW_W-1:0] result_row;
    logic [COL_W-1:0] result_col;
    logic             result_hit;
`ifdef SAD_REPORT_EN
    logic [SAD_W-1:0] result_sad;
`endif

    // Producer of samples and consumer of results.
    modport master (
        output frame_start, frame_done, sad_valid, sad_cb, sad_value, sad_row, sad_col,
        output result_ready,
`ifdef SAD_REPORT_EN
        input  result_sad,
`endif
        input  busy, result_valid, result_cb, result_row, result_col, result_hit
    );

    // The decision block itself.
    modport slave (
        input  frame_start, frame_done, sad_valid, sad_cb, sad_value, sad_row, sad_col,
        input  result_ready,
`ifdef SAD_REPORT_EN
        output result_sad,
`endif
        output busy, result_valid, result_cb, result_row, result_col, result_hit
    );

endinterface

// File: rtl/me_min_slot.sv
// One compare/update slot: keeps the lowest SAD seen for a sub-block and
// the row/column where it occurred. Earlier candidates win ties.
// Optional feature: SAD_REPORT_EN exposes the stored SAD on port sad.
module me_min_slot
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             update,
    input  logic [SAD_W-1:0] cand_sad,
    input  logic [ROW_W-1:0] cand_row,
    input  logic [COL_W-1:0] cand_col,
`ifdef SAD_REPORT_EN
    output logic [SAD_W-1:0] sad,
`endif
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             hit
);

    logic [SAD_W-1:0] stored_sad;

    // Track the running minimum; the first sample always lands, even at SAD_INIT.
    always_ff @(posedge clk) begin
        // NOTE: registers take <= so every slot samples pre-edge values together.
        if (rst || clear) begin
            // NOTE: the storage is reset explicitly; an empty slot must read as
            // "no hit, row 0, col 0, SAD_INIT", not whatever the last frame left.
            stored_sad <= SAD_INIT;
            row        <= '0;
            col        <= '0;
            hit        <= 1'b0;
        end else if (update) begin
            hit <= 1'b1;
            if (!hit || (cand_sad < stored_sad)) begin
                stored_sad <= cand_sad;
                row        <= cand_row;
                col        <= cand_col;
            end
        end
    end

`ifdef SAD_REPORT_EN
    assign sad = stored_sad;
`endif

endmodule

// File: rtl/me_mv_decision.sv
// Motion-vector decision: collects SAD samples for four coding sub-blocks
// during a search window, then emits the best candidate per sub-block in
// order CB0..CB3 over a valid/ready handshake.
// Optional feature: SAD_REPORT_EN adds result_sad (best SAD of the sub-block).
module me_mv_decision
    import me_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    me_mv_decision_if.slave   bus
);

    state_t state, state_next;
    logic   valid, valid_next;
    cb_t    cb, cb_next;
    logic   clear_all;
    logic   sample_en;

    logic [ROW_W-1:0] slot_row [CB_NUM];
    logic [COL_W-1:0] slot_col [CB_NUM];
    logic             slot_hit [CB_NUM];
`ifdef SAD_REPORT_EN
    logic [SAD_W-1:0] slot_sad [CB_NUM];
`endif

    for (genvar g = 0; g < CB_NUM; g++) begin : g_slot
        me_min_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear_all),
            .update   (sample_en && (bus.sad_cb == cb_t'(g))),
            .cand_sad (bus.sad_value),
            .cand_row (bus.sad_row),
            .cand_col (bus.sad_col),
`ifdef SAD_REPORT_EN
            .sad      (slot_sad[g]),
`endif
            .row      (slot_row[g]),
            .col      (slot_col[g]),
            .hit      (slot_hit[g])
        );
    end

    // Next-state, emission sequencing and slot strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_next = state;
        valid_next = valid;
        cb_next    = cb;
        clear_all  = 1'b0;
        sample_en  = 1'b0;

        if (bus.frame_start) begin
            // A new window wins over everything else, including a pending result.
            clear_all  = 1'b1;
            state_next = COLLECT;
            valid_next = 1'b0;
            cb_next    = '0;
        end else begin
            unique case (state)
                IDLE: ;
                COLLECT: begin
                    sample_en = bus.sad_valid;
                    if (bus.frame_done) begin
                        state_next = EMIT;
                        valid_next = 1'b0;
                        cb_next    = '0;
                    end
                end
                EMIT: begin
                    if (!valid) begin
                        valid_next = 1'b1;
                    end else if (bus.result_ready) begin
                        if (cb == cb_t'(CB_NUM - 1)) begin
                            valid_next = 1'b0;
                            cb_next    = '0;
                            state_next = IDLE;
                        end else begin
                            cb_next = cb + cb_t'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and result-pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= 1'b0;
            cb    <= '0;
        end else begin
            state <= state_next;
            valid <= valid_next;
            cb    <= cb_next;
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = valid;
    assign bus.result_cb    = cb;
    assign bus.result_row   = slot_row[cb];
    assign bus.result_col   = slot_col[cb];
    assign bus.result_hit   = slot_hit[cb];
`ifdef SAD_REPORT_EN
    assign bus.result_sad   = slot_sad[cb];
`endif

endmodule

// File: tb/tb_me_mv_decision.sv
// Self-checking bench for me_mv_decision: table vectors, hand-written
// multi-cycle sequences and randomized frames against a minimum model.
module tb_me_mv_decision;
    import me_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    me_mv_decision_if bus();

    me_mv_decision dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: best candidate per sub-block for the current window.
    logic [15:0] m_sad [4];
    logic [6:0]  m_row [4];
    logic [4:0]  m_col [4];
    logic        m_hit [4];

    typedef struct packed {
        logic [1:0]        n;
        logic [1:0]        cb;
        logic [0:2][15:0]  sad;
        logic [0:2][6:0]   row;
        logic [0:2][4:0]   col;
        logic [15:0]       e_sad;
        logic [6:0]        e_row;
        logic [4:0]        e_col;
        logic              e_hit;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_sad[i] = 16'hFFFF;
            m_row[i] = '0;
            m_col[i] = '0;
            m_hit[i] = 1'b0;
        end
    endtask

    task automatic model_sample(input int cb, input logic [15:0] v, input logic [6:0] r,
                                input logic [4:0] c);
        if (!m_hit[cb] || v < m_sad[cb]) begin
            m_sad[cb] = v;
            m_row[cb] = r;
            m_col[cb] = c;
        end
        m_hit[cb] = 1'b1;
    endtask

    task automatic start_frame();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        model_clear();
    endtask

    task automatic end_frame();
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
    endtask

    // One sample cycle; apply selects whether the model should see it.
    task automatic sample(input int cb, input logic [15:0] v, input logic [6:0] r,
                          input logic [4:0] c, input bit done, input bit apply);
        bus.sad_valid  = 1'b1;
        bus.sad_cb     = 2'(cb);
        bus.sad_value  = v;
        bus.sad_row    = r;
        bus.sad_col    = c;
        bus.frame_done = done;
        step();
        bus.sad_valid  = 1'b0;
        bus.frame_done = 1'b0;
        if (apply) model_sample(cb, v, r, c);
    endtask

    task automatic check_result(input string tag, input int cb);
        check($sformatf("%s_valid%0d", tag, cb), bus.result_valid, 1);
        check($sformatf("%s_cb%0d", tag, cb), bus.result_cb, cb);
        check($sformatf("%s_row%0d", tag, cb), bus.result_row, m_row[cb]);
        check($sformatf("%s_col%0d", tag, cb), bus.result_col, m_col[cb]);
        check($sformatf("%s_hit%0d", tag, cb), bus.result_hit, m_hit[cb]);
`ifdef SAD_REPORT_EN
        check($sformatf("%s_sad%0d", tag, cb), bus.result_sad, m_sad[cb]);
`endif
    endtask

    task automatic wait_valid(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.result_valid) begin
                ok = 1'b1;
                return;
            end
            step();
        end
        ok = bus.result_valid;
        if (!ok) check($sformatf("%s_valid_timeout", tag), bus.result_valid, 1);
    endtask

    // Drain CB0..CB3 with up to max_stall ready-low cycles before each accept.
    task automatic emit_all(input string tag, input int max_stall);
        bit ok;
        wait_valid(tag, ok);
        if (!ok) return;
        for (int cb = 0; cb < 4; cb++) begin
            int n;
            n = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
            bus.result_ready = 1'b0;
            for (int s = 0; s < n; s++) begin
                check_result($sformatf("%s_stall", tag), cb);
                step();
            end
            bus.result_ready = 1'b1;
            check_result(tag, cb);
            step();
            bus.result_ready = 1'b0;
        end
        check($sformatf("%s_valid_after", tag), bus.result_valid, 0);
        check($sformatf("%s_busy_after", tag), bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;

        vecs[0] = '{n: 2'd3, cb: 2'd0, sad: '{16'd500, 16'd300, 16'd300}, row: '{7'd3, 7'd9, 7'd12},
                    col: '{5'd1, 5'd2, 5'd4}, e_sad: 16'd300, e_row: 7'd9, e_col: 5'd2, e_hit: 1'b1};
        vecs[1] = '{n: 2'd1, cb: 2'd2, sad: '{16'd1234, 16'd0, 16'd0}, row: '{7'd5, 7'd0, 7'd0},
                    col: '{5'd6, 5'd0, 5'd0}, e_sad: 16'd1234, e_row: 7'd5, e_col: 5'd6, e_hit: 1'b1};
        vecs[2] = '{n: 2'd1, cb: 2'd1, sad: '{16'hFFFF, 16'd0, 16'd0}, row: '{7'd7, 7'd0, 7'd0},
                    col: '{5'd9, 5'd0, 5'd0}, e_sad: 16'hFFFF, e_row: 7'd7, e_col: 5'd9, e_hit: 1'b1};
        vecs[3] = '{n: 2'd3, cb: 2'd3, sad: '{16'd20, 16'd20, 16'hFFFF}, row: '{7'd1, 7'd2, 7'd3},
                    col: '{5'd1, 5'd2, 5'd3}, e_sad: 16'd20, e_row: 7'd1, e_col: 5'd1, e_hit: 1'b1};
        vecs[4] = '{n: 2'd3, cb: 2'd1, sad: '{16'd100, 16'd99, 16'd0}, row: '{7'd10, 7'd11, 7'd127},
                    col: '{5'd10, 5'd11, 5'd31}, e_sad: 16'd0, e_row: 7'd127, e_col: 5'd31, e_hit: 1'b1};
        vecs[5] = '{n: 2'd0, cb: 2'd0, sad: '{16'd0, 16'd0, 16'd0}, row: '{7'd0, 7'd0, 7'd0},
                    col: '{5'd0, 5'd0, 5'd0}, e_sad: 16'hFFFF, e_row: 7'd0, e_col: 5'd0, e_hit: 1'b0};
        vecs[6] = '{n: 2'd2, cb: 2'd2, sad: '{16'hFFFF, 16'hFFFE, 16'd0}, row: '{7'd1, 7'd2, 7'd0},
                    col: '{5'd3, 5'd4, 5'd0}, e_sad: 16'hFFFE, e_row: 7'd2, e_col: 5'd4, e_hit: 1'b1};

        rst              = 1'b1;
        bus.frame_start  = 1'b0;
        bus.frame_done   = 1'b0;
        bus.sad_valid    = 1'b0;
        bus.sad_cb       = '0;
        bus.sad_value    = '0;
        bus.sad_row      = '0;
        bus.sad_col      = '0;
        bus.result_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        model_clear();

        // Reset state.
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.result_valid, 0);
        check("rst_cb", bus.result_cb, 0);
        check("rst_row", bus.result_row, 0);
        check("rst_col", bus.result_col, 0);
        check("rst_hit", bus.result_hit, 0);
`ifdef SAD_REPORT_EN
        check("rst_sad", bus.result_sad, 16'hFFFF);
`endif

        // Table vectors: one frame per record, the other sub-blocks stay empty.
        for (int i = 0; i < 7; i++) begin
            start_frame();
            for (int k = 0; k < int'(vecs[i].n); k++)
                sample(int'(vecs[i].cb), vecs[i].sad[k], vecs[i].row[k], vecs[i].col[k], 1'b0, 1'b0);
            end_frame();
            model_clear();
            m_sad[vecs[i].cb] = vecs[i].e_sad;
            m_row[vecs[i].cb] = vecs[i].e_row;
            m_col[vecs[i].cb] = vecs[i].e_col;
            m_hit[vecs[i].cb] = vecs[i].e_hit;
            emit_all($sformatf("vec%0d", i), 1);
        end

        // Emission latency, 5-cycle stall, then back-to-back accepts.
        start_frame();
        sample(0, 16'd77, 7'd1, 5'd2, 1'b0, 1'b1);
        sample(3, 16'd5, 7'd6, 5'd7, 1'b0, 1'b1);
        end_frame();
        check("lat_busy", bus.busy, 1);
        check("lat_valid_low", bus.result_valid, 0);
        step();
        for (int s = 0; s < 5; s++) begin
            check_result("hold", 0);
            step();
        end
        bus.result_ready = 1'b1;
        for (int cb = 0; cb < 4; cb++) begin
            check_result("b2b", cb);
            step();
        end
        bus.result_ready = 1'b0;
        check("b2b_valid_after", bus.result_valid, 0);
        check("b2b_busy_after", bus.busy, 0);

        // Last sample arrives together with frame_done.
        start_frame();
        sample(1, 16'd10, 7'd40, 5'd7, 1'b1, 1'b1);
        emit_all("same_cycle", 0);

        // Reset after CB1 was accepted, then a fresh frame.
        start_frame();
        sample(0, 16'd3, 7'd4, 5'd5, 1'b0, 1'b1);
        sample(1, 16'd6, 7'd7, 5'd8, 1'b0, 1'b1);
        sample(2, 16'd9, 7'd10, 5'd11, 1'b0, 1'b1);
        end_frame();
        wait_valid("mid_rst", ok);
        bus.result_ready = 1'b1;
        check_result("mid_rst", 0);
        step();
        check_result("mid_rst", 1);
        step();
        bus.result_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", bus.result_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_cb", bus.result_cb, 0);
        check("mid_rst_row", bus.result_row, 0);
        check("mid_rst_hit", bus.result_hit, 0);
        step();
        check("mid_rst_valid_later", bus.result_valid, 0);
        start_frame();
        sample(3, 16'd100, 7'd1, 5'd1, 1'b0, 1'b1);
        end_frame();
        emit_all("fresh", 0);

        // Samples in IDLE are ignored.
        sample(0, 16'd1, 7'd1, 5'd1, 1'b0, 1'b0);
        check("idle_sample_busy", bus.busy, 0);
        start_frame();
        end_frame();
        emit_all("idle_sample", 0);

        // Samples during EMIT ignored; frame_start during EMIT restarts.
        start_frame();
        sample(2, 16'd50, 7'd2, 5'd2, 1'b0, 1'b1);
        end_frame();
        wait_valid("emit_ign", ok);
        sample(2, 16'd1, 7'd9, 5'd9, 1'b0, 1'b0);
        check_result("emit_ign", 0);
        bus.result_ready = 1'b1;
        step();
        step();
        bus.result_ready = 1'b0;
        check_result("emit_ign", 2);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        model_clear();
        check("restart_valid", bus.result_valid, 0);
        check("restart_busy", bus.busy, 1);
        end_frame();
        emit_all("restart", 0);

        // frame_done outside COLLECT does nothing.
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        check("idle_done_busy", bus.busy, 0);
        step();
        check("idle_done_valid", bus.result_valid, 0);

        // Reset dominates frame_start.
        rst = 1'b1;
        bus.frame_start = 1'b1;
        step();
        rst = 1'b0;
        bus.frame_start = 1'b0;
        check("rst_dom_busy", bus.busy, 0);

        // Randomized frames against the model.
        for (int f = 0; f < 25; f++) begin
            int  n;
            bit  closed;
            closed = 1'b0;
            start_frame();
            n = int'($urandom_range(0, 10));
            for (int j = 0; j < n; j++) begin
                logic [15:0] v;
                bit          done;
                if ($urandom_range(0, 3) == 0) step();
                v    = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 20));
                done = (j == n - 1) && ($urandom_range(0, 1) == 1);
                sample(int'($urandom_range(0, 3)), v, 7'($urandom_range(0, 127)),
                       5'($urandom_range(0, 31)), done, 1'b1);
                closed = done;
            end
            if (!closed) end_frame();
            emit_all($sformatf("rnd%0d", f), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
